// File: rtl/change_dispenser.sv
// Change pay-out sequencer: turns a latched amount (units of 100) into timed 500/100 ejector pulses.
// Optional macro CHANGE_TUBE_SENSE_EN enables the tube-empty sensors, 100-coin substitution and FAULT.
module change_dispenser #(
  parameter int unsigned PULSE_CYCLES = 10_000_000,
  parameter int unsigned GAP_CYCLES   = 20_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] amount,
  input  logic       empty500,
  input  logic       empty100,
  output logic       busy,
  output logic       done,
  output logic       coin500,
  output logic       coin100,
  output logic [3:0] remaining,
  output logic       fault
);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    PULSE,
    GAP,
    DONE,
    FAULT
  } state_t;

  localparam logic [31:0] PULSE_LAST = 32'(PULSE_CYCLES - 1);
  localparam logic [31:0] GAP_LAST   = 32'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  rem_q, rem_d;
  logic        sel500_q, sel500_d;
  logic        tube500_empty, tube100_empty;

`ifdef CHANGE_TUBE_SENSE_EN
  assign tube500_empty = empty500;
  assign tube100_empty = empty100;
  assign fault         = (state_q == FAULT);
`else
  // With sensing disabled the 100 branch in SELECT always matches, so FAULT cannot be entered.
  logic unused_sensors;
  assign unused_sensors = &{1'b0, empty500, empty100};
  assign tube500_empty  = 1'b0;
  assign tube100_empty  = 1'b0;
  assign fault          = 1'b0;
`endif

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    sel500_d = sel500_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          rem_d   = amount;
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (rem_q == 4'd0) begin
          state_d = DONE;
        end else if (rem_q >= 4'd5 && !tube500_empty) begin
          sel500_d = 1'b1;
          state_d  = PULSE;
        end else if (!tube100_empty) begin
          sel500_d = 1'b0;
          state_d  = PULSE;
        end else begin
          state_d = FAULT;
        end
      end
      PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          rem_d   = rem_q - (sel500_q ? 4'd5 : 4'd1);
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) state_d = SELECT;
      end
      DONE:    state_d = IDLE;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase

    // The counter restarts on every state entry and only advances in the timed states.
    if (state_d != state_q)                      cnt_d = '0;
    else if (state_q == PULSE || state_q == GAP) cnt_d = cnt_q + 32'd1;
    else                                         cnt_d = cnt_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      sel500_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      sel500_q <= sel500_d;
    end
  end

  // Outputs decode registered state only, so reset clears them without waiting for a clock edge.
  assign busy      = (state_q != IDLE) && (state_q != FAULT);
  assign done      = (state_q == DONE);
  assign coin500   = (state_q == PULSE) &&  sel500_q;
  assign coin100   = (state_q == PULSE) && !sel500_q;
  assign remaining = rem_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: drivers queue expected coin/done events, a monitor checks them.
module tb_change_dispenser;

  localparam int P = 4;
  localparam int G = 3;
  localparam int K_DONE = 0, K_C100 = 1, K_C500 = 2;

  typedef struct {
    int kind;
    int rel;
    int width;
    int rem;
  } ev_t;

  logic       clk, reset, start, empty500, empty100;
  logic [3:0] amount;
  logic       busy, done, coin500, coin100, fault;
  logic [3:0] remaining;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  edge_n = 0;
  int  t0 = 0;
  ev_t exp_q[$];

  change_dispenser #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clk(clk), .reset(reset), .start(start), .amount(amount),
    .empty500(empty500), .empty100(empty100),
    .busy(busy), .done(done), .coin500(coin500), .coin100(coin100),
    .remaining(remaining), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic push(input int kind, input int rel, input int width, input int rem);
    ev_t e;
    e.kind = kind; e.rel = rel; e.width = width; e.rem = rem;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start is sampled at edge t0; returns 1 time unit after edge t0.
  task automatic do_start(input logic [3:0] a);
    tick();
    start  = 1'b1;
    amount = a;
    t0     = edge_n + 1;
    tick();
    start  = 1'b0;
    amount = 4'd0;
  endtask

  task automatic wait_drain(input string name);
    int i = 0;
    while (exp_q.size() != 0 && i < 300) begin
      tick();
      i++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
    check({name, "_idle_busy"}, busy, 0);
  endtask

  // Monitor: measures every high run of done/coin100/coin500 and scores it when it ends.
  int  run[3];
  int  rise[3];
  ev_t got;
  always @(negedge clk) begin
    if (coin500 || coin100) check("coin_exclusive", coin500 & coin100, 0);
    for (int k = 0; k < 3; k++) begin
      logic s;
      s = (k == K_DONE) ? done : (k == K_C100) ? coin100 : coin500;
      if (s) begin
        if (run[k] == 0) rise[k] = edge_n - t0;
        run[k]++;
      end else if (run[k] > 0) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: kind %0d at rel edge %0d, none expected", k, rise[k]);
        end else begin
          got = exp_q.pop_front();
          check("ev_kind", k, got.kind);
          check("ev_rise_edge", rise[k], got.rel);
          check("ev_width", run[k], got.width);
          check("ev_remaining", remaining, got.rem);
        end
        run[k] = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; amount = 4'd0; empty500 = 1'b0; empty100 = 1'b0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_coins", {coin500, coin100}, 0);
    check("rst_remaining", remaining, 0);
    check("rst_fault", fault, 0);
    tick(); tick();
    reset = 1'b0;

    // amount 7: 500, 100, 100 then done at edge 25
    push(K_C500, 1, P, 2);
    push(K_C100, 9, P, 1);
    push(K_C100, 17, P, 0);
    push(K_DONE, 25, 1, 0);
    do_start(4'd7);
    check("a7_busy", busy, 1);
    check("a7_remaining", remaining, 7);
    wait_drain("a7");

    // amount 0: done after edge 1, busy for two cycles
    push(K_DONE, 1, 1, 0);
    do_start(4'd0);
    check("a0_busy_e0", busy, 1);
    check("a0_done_e0", done, 0);
    tick();
    check("a0_busy_e1", busy, 1);
    check("a0_done_e1", done, 1);
    tick();
    check("a0_busy_e2", busy, 0);
    check("a0_done_e2", done, 0);
    wait_drain("a0");

`ifdef CHANGE_TUBE_SENSE_EN
    // 500 tube empty: six 100 coins, done at edge 49
    empty500 = 1'b1;
    for (int i = 0; i < 6; i++) push(K_C100, 1 + 8 * i, P, 5 - i);
    push(K_DONE, 49, 1, 0);
    do_start(4'd6);
    wait_drain("sub6");

    // both tubes empty: FAULT, sticky, start ignored
    empty100 = 1'b1;
    do_start(4'd3);
    tick();
    check("flt_fault", fault, 1);
    check("flt_busy", busy, 0);
    check("flt_remaining", remaining, 3);
    check("flt_coins", {coin500, coin100}, 0);
    do_start(4'd9);
    tick(); tick();
    check("flt_sticky", fault, 1);
    check("flt_no_reload", remaining, 3);
    reset = 1'b1;
    #1;
    check("flt_reset_fault", fault, 0);
    check("flt_reset_remaining", remaining, 0);
    tick();
    reset = 1'b0;
    empty500 = 1'b0;
    empty100 = 1'b0;
`else
    // sensing disabled: sensors ignored, three 100 coins, no fault
    empty500 = 1'b1;
    empty100 = 1'b1;
    push(K_C100, 1, P, 2);
    push(K_C100, 9, P, 1);
    push(K_C100, 17, P, 0);
    push(K_DONE, 25, 1, 0);
    do_start(4'd3);
    tick();
    check("nosense_fault", fault, 0);
    wait_drain("nosense");
    empty500 = 1'b0;
    empty100 = 1'b0;
`endif

    // reset two cycles into the 500 pulse, then a fresh single 100 pay-out
    push(K_C500, 1, 2, 0);
    do_start(4'd5);
    tick(); tick(); tick();
    check("rmid_coin500_high", coin500, 1);
    reset = 1'b1;
    #1;
    check("rmid_coin500_async", coin500, 0);
    check("rmid_busy", busy, 0);
    check("rmid_remaining", remaining, 0);
    check("rmid_done", done, 0);
    tick(); tick();
    reset = 1'b0;
    push(K_C100, 1, P, 0);
    push(K_DONE, 9, 1, 0);
    do_start(4'd1);
    wait_drain("rfresh");

    // start with amount 9 during an amount-1 pulse is ignored
    push(K_C100, 1, P, 0);
    push(K_DONE, 9, 1, 0);
    do_start(4'd1);
    tick(); tick();
    start  = 1'b1;
    amount = 4'd9;
    tick();
    start  = 1'b0;
    amount = 4'd0;
    check("ign_remaining", remaining, 1);
    wait_drain("ign");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
